// File: rtl/vram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_arbiter_if : video / CPU / single-port RAM signal bundle               |
// | Revision        : 1.0                                                       |
// +----------------------------------------------------------------------------+
interface vram_arbiter_if;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        vid_miss;

  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_wait;

  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_data, vid_valid, vid_miss, cpu_rdata, cpu_ack, cpu_wait,
           ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_data, vid_valid, vid_miss, cpu_rdata, cpu_ack, cpu_wait,
           ram_addr, ram_we, ram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vram_arbiter : shares one single-port VRAM between video fetch and CPU;     |
// |                video has priority, CPU is forced in after MAX_WAIT cycles.  |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
module vram_arbiter #(
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  vram_arbiter_if.slave bus
);

  localparam int c_CNT_W = ($clog2(MAX_WAIT + 1) < 4) ? 4 : $clog2(MAX_WAIT + 1);
  localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_WAIT);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_PEND   = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_ACK    = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic [12:0]        r_addr;
  logic               r_we;
  logic [7:0]         r_wdata;
  logic               r_vid_slot;
  logic               r_vid_valid;
  logic               r_vid_miss;
  logic [7:0]         r_vid_data;
  logic [7:0]         r_cpu_rdata;
  logic               w_in_access;

  assign w_in_access = (r_state == c_ACCESS);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (bus.cpu_req) w_state_nxt = c_PEND;
      c_PEND:   if (!bus.vid_req || (r_wait_cnt == c_MAX)) w_state_nxt = c_ACCESS;
      c_ACCESS: w_state_nxt = c_ACK;
      c_ACK:    w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == c_IDLE) && bus.cpu_req) begin
        r_addr     <= bus.cpu_addr;
        r_we       <= bus.cpu_we;
        r_wdata    <= bus.cpu_wdata;
        r_wait_cnt <= '0;
      end else if ((r_state == c_PEND) && (w_state_nxt == c_PEND) && (r_wait_cnt != '1)) begin
        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
      end
    end
  end

  // Synchronous RAM: data for an address shows on ram_rdata one cycle later,
  // so both the video return and the CPU read capture one cycle after their slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vid_slot  <= 1'b0;
      r_vid_valid <= 1'b0;
      r_vid_miss  <= 1'b0;
      r_vid_data  <= '0;
      r_cpu_rdata <= '0;
    end else begin
      r_vid_slot  <= bus.vid_req && !w_in_access;
      r_vid_valid <= r_vid_slot;
      r_vid_miss  <= bus.vid_req && w_in_access;
      if (r_vid_slot) r_vid_data <= bus.ram_rdata;
      if ((r_state == c_ACK) && !r_we) r_cpu_rdata <= bus.ram_rdata;
    end
  end

  assign bus.ram_addr  = w_in_access ? r_addr : bus.vid_addr;
  assign bus.ram_we    = w_in_access && r_we;
  assign bus.ram_wdata = r_wdata;

  assign bus.vid_data  = r_vid_data;
  assign bus.vid_valid = r_vid_valid;
  assign bus.vid_miss  = r_vid_miss;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_ack   = (r_state == c_ACK);
  assign bus.cpu_wait  = bus.cpu_req && !bus.cpu_ack;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vram_arbiter : directed self-checking bench with a synchronous RAM model |
// | Revision        : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_vram_arbiter;
  localparam int MAX_WAIT = 15;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vram_arbiter_if bus ();

  vram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:8191];

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    reset = 1'b0;
    tick; tick;
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack: got %b expected 0", bus.cpu_ack); end
    checks++; if (bus.vid_valid !== 1'b0) begin errors++; $display("FAIL reset_vid_valid: got %b expected 0", bus.vid_valid); end
    checks++; if (bus.vid_miss !== 1'b0) begin errors++; $display("FAIL reset_vid_miss: got %b expected 0", bus.vid_miss); end
    checks++; if (bus.vid_data !== 8'h00) begin errors++; $display("FAIL reset_vid_data: got %h expected 00", bus.vid_data); end
    checks++; if (bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_cpu_rdata: got %h expected 00", bus.cpu_rdata); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b expected 0", bus.ram_we); end
    checks++; if (bus.cpu_wait !== 1'b0) begin errors++; $display("FAIL reset_cpu_wait: got %b expected 0", bus.cpu_wait); end
    bus.vid_addr = 13'h0ABC;
    #1;
    checks++; if (bus.ram_addr !== 13'h0ABC) begin errors++; $display("FAIL reset_ram_addr: got %h expected 0abc", bus.ram_addr); end
    @(negedge clk);
    reset = 1'b1;
    tick;
  endtask

  task automatic test_cpu_basic;
    int n;
    logic seen_we;
    bus.vid_req = 1'b0;
    bus.cpu_we = 1'b1; bus.cpu_addr = 13'h1A5; bus.cpu_wdata = 8'h3C; bus.cpu_req = 1'b1;
    n = 0; seen_we = 1'b0;
    do begin
      tick; n++;
      if (bus.ram_we && bus.ram_addr == 13'h1A5 && bus.ram_wdata == 8'h3C) seen_we = 1'b1;
      if (n == 1) begin
        checks++; if (bus.cpu_wait !== 1'b1) begin errors++; $display("FAIL basic_cpu_wait: got %b expected 1", bus.cpu_wait); end
      end
    end while (!bus.cpu_ack && n < 20);
    checks++; if (n != 3) begin errors++; $display("FAIL basic_write_latency: got %0d expected 3", n); end
    checks++; if (bus.cpu_wait !== 1'b0) begin errors++; $display("FAIL basic_wait_at_ack: got %b expected 0", bus.cpu_wait); end
    checks++; if (seen_we !== 1'b1) begin errors++; $display("FAIL basic_ram_write: got %b expected 1", seen_we); end
    checks++; if (mem[13'h1A5] !== 8'h3C) begin errors++; $display("FAIL basic_mem_1a5: got %h expected 3c", mem[13'h1A5]); end
    bus.cpu_req = 1'b0;
    tick;
    bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
    n = 0;
    do begin tick; n++; end while (!bus.cpu_ack && n < 20);
    checks++; if (n != 3) begin errors++; $display("FAIL basic_read_latency: got %0d expected 3", n); end
    bus.cpu_req = 1'b0;
    tick;
    checks++; if (bus.cpu_rdata !== 8'h3C) begin errors++; $display("FAIL basic_read_data: got %h expected 3c", bus.cpu_rdata); end
    tick;
  endtask

  task automatic test_max_wait;
    logic [7:0] exp_d;
    logic       exp_v;
    bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0155; bus.cpu_req = 1'b1;
    bus.vid_req = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      bus.vid_addr = 13'h0800 + 13'(k - 1);
      tick;
      exp_v = (k >= 2) && (k != 19);
      exp_d = 8'(k - 2);
      checks++; if (bus.cpu_ack !== (k == 18)) begin errors++; $display("FAIL maxwait_ack k=%0d: got %b expected %b", k, bus.cpu_ack, (k == 18)); end
      checks++; if (bus.vid_miss !== (k == 18)) begin errors++; $display("FAIL maxwait_miss k=%0d: got %b expected %b", k, bus.vid_miss, (k == 18)); end
      checks++; if (bus.vid_valid !== exp_v) begin errors++; $display("FAIL maxwait_valid k=%0d: got %b expected %b", k, bus.vid_valid, exp_v); end
      if (exp_v) begin
        checks++; if (bus.vid_data !== exp_d) begin errors++; $display("FAIL maxwait_vdata k=%0d: got %h expected %h", k, bus.vid_data, exp_d); end
      end
      if (k == 17) begin
        checks++; if (bus.ram_addr !== 13'h0155) begin errors++; $display("FAIL maxwait_ram_addr: got %h expected 0155", bus.ram_addr); end
      end
      if (k == 19) begin
        checks++; if (bus.cpu_rdata !== 8'h55) begin errors++; $display("FAIL maxwait_rdata: got %h expected 55", bus.cpu_rdata); end
      end
      checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL maxwait_ram_we k=%0d: got %b expected 0", k, bus.ram_we); end
      if (bus.cpu_ack) bus.cpu_req = 1'b0;
    end
    bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_gap;
    logic [7:0] pat;
    logic       exp_v;
    pat = 8'b0001_0011;  // vid_req per cycle, bit 0 first: 1,1,0,0,1
    bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0300; bus.cpu_wdata = 8'hC3; bus.cpu_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      bus.vid_req  = pat[k-1];
      bus.vid_addr = 13'h0900 + 13'(k - 1);
      tick;
      exp_v = (k >= 2) ? pat[k-2] : 1'b0;
      checks++; if (bus.cpu_ack !== (k == 4)) begin errors++; $display("FAIL gap_ack k=%0d: got %b expected %b", k, bus.cpu_ack, (k == 4)); end
      checks++; if (bus.vid_miss !== 1'b0) begin errors++; $display("FAIL gap_miss k=%0d: got %b expected 0", k, bus.vid_miss); end
      checks++; if (bus.vid_valid !== exp_v) begin errors++; $display("FAIL gap_valid k=%0d: got %b expected %b", k, bus.vid_valid, exp_v); end
      if (exp_v) begin
        checks++; if (bus.vid_data !== 8'(k - 2)) begin errors++; $display("FAIL gap_vdata k=%0d: got %h expected %h", k, bus.vid_data, 8'(k - 2)); end
      end
      checks++; if (bus.ram_we !== (k == 3)) begin errors++; $display("FAIL gap_ram_we k=%0d: got %b expected %b", k, bus.ram_we, (k == 3)); end
      if (bus.cpu_ack) bus.cpu_req = 1'b0;
    end
    checks++; if (mem[13'h0300] !== 8'hC3) begin errors++; $display("FAIL gap_mem_300: got %h expected c3", mem[13'h0300]); end
  endtask

  task automatic test_video;
    logic [7:0]  pat;
    logic [12:0] addr_q [0:7];
    logic        exp_v;
    pat = 8'b0010_1101;  // bit 0 first: 1,0,1,1,0,1
    bus.cpu_req = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      addr_q[(k-1) % 8] = 13'h0A10 + 13'((k - 1) * 3);
      bus.vid_req  = (k <= 6) ? pat[k-1] : 1'b0;
      bus.vid_addr = addr_q[(k-1) % 8];
      tick;
      exp_v = (k >= 2 && k <= 7) ? pat[k-2] : 1'b0;
      checks++; if (bus.vid_valid !== exp_v) begin errors++; $display("FAIL video_valid k=%0d: got %b expected %b", k, bus.vid_valid, exp_v); end
      if (exp_v) begin
        checks++; if (bus.vid_data !== addr_q[(k-2) % 8][7:0]) begin errors++; $display("FAIL video_data k=%0d: got %h expected %h", k, bus.vid_data, addr_q[(k-2) % 8][7:0]); end
      end
    end
  endtask

  task automatic test_reset_mid_access;
    bus.vid_req = 1'b0;
    bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0444; bus.cpu_wdata = 8'hEE; bus.cpu_req = 1'b1;
    tick; tick;
    checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL rstmid_ram_we_before: got %b expected 1", bus.ram_we); end
    reset = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rstmid_ram_we_async: got %b expected 0", bus.ram_we); end
    checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack_async: got %b expected 0", bus.cpu_ack); end
    tick;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL rstmid_no_ack k=%0d: got %b expected 0", k, bus.cpu_ack); end
    end
    checks++; if (mem[13'h0444] !== 8'h44) begin errors++; $display("FAIL rstmid_mem_444: got %h expected 44", mem[13'h0444]); end
  endtask

  task automatic test_back_to_back;
    int first_ack, second_ack, n_ack;
    first_ack = -1; second_ack = -1; n_ack = 0;
    bus.vid_req = 1'b0;
    bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0010; bus.cpu_wdata = 8'h11; bus.cpu_req = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick;
      if (bus.cpu_ack) begin
        n_ack++;
        if (n_ack == 1) begin
          first_ack = k;
          bus.cpu_addr = 13'h0011; bus.cpu_wdata = 8'h22;
        end else begin
          second_ack = k;
          bus.cpu_req = 1'b0;
        end
      end
    end
    bus.cpu_req = 1'b0;
    checks++; if (first_ack != 3) begin errors++; $display("FAIL b2b_first_ack: got %0d expected 3", first_ack); end
    checks++; if (second_ack != 7) begin errors++; $display("FAIL b2b_second_ack: got %0d expected 7", second_ack); end
    checks++; if (n_ack != 2) begin errors++; $display("FAIL b2b_ack_count: got %0d expected 2", n_ack); end
    checks++; if (mem[13'h0010] !== 8'h11) begin errors++; $display("FAIL b2b_mem_010: got %h expected 11", mem[13'h0010]); end
    checks++; if (mem[13'h0011] !== 8'h22) begin errors++; $display("FAIL b2b_mem_011: got %h expected 22", mem[13'h0011]); end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i);
    bus.ram_rdata = 8'h00;
    test_reset();
    test_cpu_basic();
    test_max_wait();
    test_gap();
    tick; tick;
    test_video();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
`default_nettype wire
